wb_pipe2std_bridge: RTL and testbench
=====================================

Name: wb_pipe2std_bridge

Overview:
- Bridges a Wishbone B4 pipelined master onto a Wishbone classic (standard) slave.
- Buffers up to `depth` outstanding pipelined requests in an in-order FIFO and replays them one at a time as classic cycles.
- Returns ack/err to the master in request order.
- Successor to the fixed-width, fixed-wait standard-slave wrapper. Adds parametrised address/data/select widths, configurable buffering, byte selects, error propagation, a bus-timeout watchdog and clean abort on master CYC drop.

Parameters:
- adr_width, 16, address width in bits.
- dat_width, 16, data width in bits; must be a multiple of 8.
- sel_width, dat_width/8, byte-select width.
- depth, 4, request FIFO entries; power of two, 2..16.
- timeout, 0, watchdog limit in cycles of downstream STB without termination; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- s_cyc  in  1  master bus cycle.
- s_stb  in  1  master strobe.
- s_we  in  1  master write enable.
- s_adr  in  adr_width  master address.
- s_sel  in  sel_width  master byte selects.
- s_dat_m  in  dat_width  master write data.
- s_dat_s  out  dat_width  read data to master.
- s_ack  out  1  normal termination to master.
- s_err  out  1  error termination to master.
- s_stall  out  1  pipeline stall to master.
- m_cyc  out  1  classic cycle to slave.
- m_stb  out  1  classic strobe to slave.
- m_we  out  1  classic write enable.
- m_adr  out  adr_width  classic address.
- m_sel  out  sel_width  classic byte selects.
- m_dat_m  out  dat_width  classic write data.
- m_dat_s  in  dat_width  classic read data.
- m_ack  in  1  classic acknowledge.
- m_err  in  1  classic error.

Behaviour:
- Reset: FIFO empty; FSM IDLE; watchdog cleared. m_cyc, m_stb, m_we, s_ack, s_err = 0. m_adr, m_sel, m_dat_m, s_dat_s = 0. s_stall = 0.
- Accept: a request is accepted when s_cyc & s_stb & !s_stall. The entry {we, adr, sel, dat} is written into the FIFO at that edge.
- s_stall is combinational and equals FIFO full. With count == depth, stall is 1 even if a pop occurs in the same cycle.
- An entry becomes visible to the FSM one cycle after it is written. Simultaneous push and pop keeps count unchanged.
- FSM IDLE:
  - Enter BUS when the FIFO is non-empty and s_cyc = 1.
  - On the transition, register the head entry onto the m_* outputs and set m_cyc = m_stb = 1.
  - m_stb therefore rises 2 cycles after acceptance into an empty bridge.
- FSM BUS: m_cyc = m_stb = 1 and outputs are held stable until termination.
- Termination in BUS:
  - Termination is m_ack | m_err | watchdog expiry.
  - Pop the head and capture m_dat_s into s_dat_s on reads; s_dat_s is unchanged on writes.
  - Register s_ack (m_ack and no m_err), or s_err (m_err, or watchdog).
  - The response is driven to the master exactly one cycle after termination is sampled, for one cycle.
- Back-to-back: if another entry is visible at termination, stay in BUS and load it on the next edge, so m_stb stays high with the new address. Otherwise go to IDLE with m_cyc = m_stb = 0.
- Simultaneous m_ack and m_err: treated as error.
- Watchdog:
  - Counts cycles in BUS and restarts at each new entry.
  - When timeout > 0 and the count reaches timeout with no m_ack/m_err, terminate with s_err.
  - m_ack or m_err in the expiry cycle takes precedence over the watchdog.
- Ordering: responses are issued strictly in acceptance order, one per accepted request.
- Abort: s_cyc = 0 at any time:
  - Flush the FIFO.
  - FSM goes to IDLE; m_cyc = m_stb = 0 on the next edge.
  - The watchdog clears.
  - No responses are issued for flushed or in-flight entries.
  - s_ack and s_err are gated with s_cyc, so a registered response is suppressed if s_cyc has dropped.
- Reset mid-operation: identical to abort, plus all outputs return to reset values on the next edge.

Test Plan:
- Single writes with slave waitcycles = 0: addr 1..10, data 101..110, CYC dropped between requests. Required: each m_stb rises 2 cycles after accept; s_ack arrives 1 cycle after m_ack; slave memory holds 101..110.
- Single reads of addr 1..10. Required: s_dat_s = 101..110 in order, each with s_ack for one cycle.
- Back-to-back pipelined writes, addr 11..20, data 211..220, with STB held and slave waitcycles = 3. Required:
  - s_stall asserts once 4 entries are queued.
  - No request is lost.
  - m_stb stays continuous across entries.
  - Exactly 10 s_ack pulses.
  - Pipelined reads of addr 11..20 then return 211..220 in order.
- Slave asserts m_err on addr 5 during a 3-request burst (addr 4, 5, 6). Required: s_ack, s_err, s_ack in that order. Repeat with m_ack and m_err asserted together on addr 5: s_err.
- timeout = 8 with a slave that never acks addr 0x7F. Required: s_err exactly 9 cycles after m_stb rose, m_stb drops, and the next queued request proceeds.
- Drop s_cyc with 3 requests queued and one in flight. Required:
  - m_cyc = 0 next cycle.
  - No s_ack or s_err.
  - A fresh cycle afterwards completes normally with FIFO count starting at 0.

Source files
------------

// File: rtl/wb_pipe2std_bridge_if.sv
// Wishbone bus bundle, used for both the pipelined upstream port and the classic downstream port.
// Only the pipelined side carries a stall, so the master modport leaves it out.
interface wb_pipe2std_bridge_if #(
    parameter int unsigned adr_width = 16,
    parameter int unsigned dat_width = 16,
    parameter int unsigned sel_width = dat_width / 8
);
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [adr_width-1:0] adr;
    logic [sel_width-1:0] sel;
    logic [dat_width-1:0] dat_m;
    logic [dat_width-1:0] dat_s;
    logic                 ack;
    logic                 err;
    logic                 stall;

    modport master (
        output cyc, stb, we, adr, sel, dat_m,
        input  dat_s, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output dat_s, ack, err, stall
    );
endinterface

// File: rtl/wb_pipe2std_bridge.sv
// Wishbone B4 pipelined-to-classic bridge: queues pipelined requests in an in-order FIFO and
// replays them as classic cycles, returning ack/err in request order.
module wb_pipe2std_bridge #(
    parameter int unsigned adr_width = 16,
    parameter int unsigned dat_width = 16,
    parameter int unsigned sel_width = dat_width / 8,
    parameter int unsigned depth     = 4,
    parameter int unsigned timeout   = 0
) (
    input logic                  clk,
    input logic                  rst,
    wb_pipe2std_bridge_if.slave  s,
    wb_pipe2std_bridge_if.master m
);
    localparam int unsigned PtrW = $clog2(depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned EntW = 1 + adr_width + sel_width + dat_width;

    typedef enum logic [0:0] {StIdle, StBus} state_e;

    state_e               state_q, state_d;
    logic [EntW-1:0]      mem_q [depth];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
    logic [CntW-1:0]      count_q, count_d;
    logic [31:0]          wd_q, wd_d;
    logic                 m_cyc_q, m_cyc_d, m_we_q, m_we_d;
    logic [adr_width-1:0] m_adr_q, m_adr_d;
    logic [sel_width-1:0] m_sel_q, m_sel_d;
    logic [dat_width-1:0] m_dat_q, m_dat_d, dat_s_q, dat_s_d;
    logic                 ack_q, ack_d, err_q, err_d;
    logic                 full, push, pop, load, wd_expire, term;
    logic [EntW-1:0]      load_entry;

    assign full       = (count_q == CntW'(depth));
    assign push       = s.cyc & s.stb & ~full;
    assign rd_ptr_nxt = rd_ptr_q + PtrW'(1);
    assign wd_expire  = (timeout != 0) && (wd_q == timeout);
    assign term       = (state_q == StBus) & (m.ack | m.err | wd_expire);

    // Entry stays at the head while it is on the bus; it is popped on termination.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s.we, s.adr, s.sel, s.dat_m};
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        wd_d       = wd_q;
        m_cyc_d    = m_cyc_q;
        m_we_d     = m_we_q;
        m_adr_d    = m_adr_q;
        m_sel_d    = m_sel_q;
        m_dat_d    = m_dat_q;
        dat_s_d    = dat_s_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        pop        = 1'b0;
        load       = 1'b0;
        load_entry = mem_q[rd_ptr_q];

        if (!s.cyc) begin
            // Abort: flush everything; in-flight and queued requests get no response.
            state_d  = StIdle;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            wd_d     = '0;
            m_cyc_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        state_d = StBus;
                        load    = 1'b1;
                    end
                end
                StBus: begin
                    if (term) begin
                        pop   = 1'b1;
                        ack_d = m.ack & ~m.err;
                        err_d = m.err | ~m.ack;
                        if (!m_we_q) begin
                            dat_s_d = m.dat_s;
                        end
                        if (count_q > CntW'(1)) begin
                            load       = 1'b1;
                            load_entry = mem_q[rd_ptr_nxt];
                        end else begin
                            state_d = StIdle;
                            m_cyc_d = 1'b0;
                            wd_d    = '0;
                        end
                    end else begin
                        wd_d = wd_q + 32'd1;
                    end
                end
            endcase

            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_nxt;
            end
            count_d = count_q + CntW'(push) - CntW'(pop);

            if (load) begin
                {m_we_d, m_adr_d, m_sel_d, m_dat_d} = load_entry;
                m_cyc_d = 1'b1;
                wd_d    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wd_q     <= '0;
            m_cyc_q  <= 1'b0;
            m_we_q   <= 1'b0;
            m_adr_q  <= '0;
            m_sel_q  <= '0;
            m_dat_q  <= '0;
            dat_s_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wd_q     <= wd_d;
            m_cyc_q  <= m_cyc_d;
            m_we_q   <= m_we_d;
            m_adr_q  <= m_adr_d;
            m_sel_q  <= m_sel_d;
            m_dat_q  <= m_dat_d;
            dat_s_q  <= dat_s_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign s.stall = full;
    assign s.ack   = ack_q & s.cyc;
    assign s.err   = err_q & s.cyc;
    assign s.dat_s = dat_s_q;

    assign m.cyc   = m_cyc_q;
    assign m.stb   = m_cyc_q;
    assign m.we    = m_we_q;
    assign m.adr   = m_adr_q;
    assign m.sel   = m_sel_q;
    assign m.dat_m = m_dat_q;
endmodule

// File: tb/tb_wb_pipe2std_bridge.sv
// Directed bench for wb_pipe2std_bridge with a behavioural classic slave (wait states, error
// address, never-acking address).
module tb_wb_pipe2std_bridge;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wb_pipe2std_bridge_if #(.adr_width(16), .dat_width(16), .sel_width(2)) s_bus ();
    wb_pipe2std_bridge_if #(.adr_width(16), .dat_width(16), .sel_width(2)) m_bus ();

    wb_pipe2std_bridge #(
        .adr_width(16),
        .dat_width(16),
        .sel_width(2),
        .depth    (4),
        .timeout  (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s  (s_bus.slave),
        .m  (m_bus.master)
    );

    int          waits;
    bit          err_en, both_en;
    logic [15:0] err_adr, hang_adr;
    int          wcnt;
    logic [15:0] mem [256];

    always @(posedge clk) begin
        if (rst) begin
            m_bus.ack   <= 1'b0;
            m_bus.err   <= 1'b0;
            m_bus.dat_s <= '0;
            wcnt        <= 0;
        end else begin
            m_bus.ack <= 1'b0;
            m_bus.err <= 1'b0;
            if (!(m_bus.cyc && m_bus.stb)) begin
                wcnt <= 0;
            end else if (!m_bus.ack && !m_bus.err) begin
                if (wcnt < waits) begin
                    wcnt <= wcnt + 1;
                end else begin
                    wcnt <= 0;
                    if (m_bus.adr != hang_adr) begin
                        if (err_en && m_bus.adr == err_adr) begin
                            m_bus.err <= 1'b1;
                            m_bus.ack <= both_en;
                        end else begin
                            m_bus.ack <= 1'b1;
                            if (m_bus.we) mem[m_bus.adr[7:0]] <= m_bus.dat_m;
                            else m_bus.dat_s <= mem[m_bus.adr[7:0]];
                        end
                    end
                end
            end
        end
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  rsp_kind [16];
    logic [15:0] rsp_dat  [16];
    int          rsp_n, gaps, first_stall_acc, acc_n;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_single(input bit we, input logic [15:0] adr, input logic [15:0] dat);
        s_bus.cyc   = 1'b1;
        s_bus.stb   = 1'b1;
        s_bus.we    = we;
        s_bus.adr   = adr;
        s_bus.sel   = 2'b11;
        s_bus.dat_m = we ? dat : 16'h0;
        chk("single_stall", s_bus.stall, 0);
        tick;
        s_bus.stb = 1'b0;
        chk("single_stb_early", m_bus.stb, 0);
        tick;
        chk("single_stb_rise", m_bus.stb, 1);
        chk("single_adr", m_bus.adr, adr);
        chk("single_we", m_bus.we, we);
        chk("single_sel", m_bus.sel, 3);
        if (we) chk("single_wdat", m_bus.dat_m, dat);
        tick;
        chk("single_mack", m_bus.ack, 1);
        chk("single_sack_early", s_bus.ack, 0);
        tick;
        chk("single_sack", s_bus.ack, 1);
        chk("single_serr", s_bus.err, 0);
        chk("single_stb_fall", m_bus.stb, 0);
        if (!we) chk("single_rdat", s_bus.dat_s, dat);
        tick;
        chk("single_sack_pulse", s_bus.ack, 0);
        s_bus.cyc = 1'b0;
        tick;
    endtask

    // Holds STB, advancing the request only when it was accepted; records responses in order.
    task automatic burst(input bit we, input int base, input int n, input int dbase);
        int i = 0;
        int budget = 0;
        bit seen = 0;
        bit acc;
        rsp_n = 0;
        gaps = 0;
        first_stall_acc = -1;
        s_bus.cyc = 1'b1;
        s_bus.we  = we;
        s_bus.sel = 2'b11;
        while ((i < n || rsp_n < n) && budget < 300) begin
            s_bus.stb   = (i < n);
            s_bus.adr   = 16'(base + i);
            s_bus.dat_m = 16'(dbase + i);
            if (s_bus.stall && first_stall_acc < 0) first_stall_acc = i;
            acc = s_bus.stb && !s_bus.stall;
            if ((s_bus.ack || s_bus.err) && rsp_n < 16) begin
                rsp_kind[rsp_n] = s_bus.err ? 2'd2 : 2'd1;
                rsp_dat[rsp_n]  = s_bus.dat_s;
                rsp_n++;
            end
            if (m_bus.stb) seen = 1;
            else if (seen && rsp_n < n) gaps++;
            tick;
            if (acc) i++;
            budget++;
        end
        s_bus.stb = 1'b0;
        acc_n = i;
        chk("burst_responses", rsp_n, n);
        chk("burst_accepted", acc_n, n);
        chk("burst_stb_gaps", gaps, 0);
    endtask

    initial begin
        int k;
        bit quiet;
        int nacks;
        rst = 1'b1;
        s_bus.cyc = 1'b0; s_bus.stb = 1'b0; s_bus.we = 1'b0;
        s_bus.adr = '0; s_bus.sel = '0; s_bus.dat_m = '0;
        waits = 0; err_en = 0; both_en = 0; err_adr = 16'd5; hang_adr = 16'h7F;
        repeat (3) tick;
        chk("rst_m_cyc", m_bus.cyc, 0);
        chk("rst_m_stb", m_bus.stb, 0);
        chk("rst_m_we", m_bus.we, 0);
        chk("rst_m_adr", m_bus.adr, 0);
        chk("rst_m_sel", m_bus.sel, 0);
        chk("rst_m_dat", m_bus.dat_m, 0);
        chk("rst_s_dat", s_bus.dat_s, 0);
        chk("rst_s_ack", s_bus.ack, 0);
        chk("rst_s_err", s_bus.err, 0);
        chk("rst_s_stall", s_bus.stall, 0);
        rst = 1'b0;
        tick;

        for (int a = 1; a <= 10; a++) do_single(1'b1, 16'(a), 16'(100 + a));
        for (int a = 1; a <= 10; a++) chk("mem_single", mem[a], 100 + a);
        for (int a = 1; a <= 10; a++) do_single(1'b0, 16'(a), 16'(100 + a));

        waits = 3;
        burst(1'b1, 11, 10, 211);
        chk("burst_first_stall", first_stall_acc, 4);
        nacks = 0;
        for (int j = 0; j < 10; j++) if (rsp_kind[j] == 2'd1) nacks++;
        chk("burst_ack_count", nacks, 10);
        s_bus.cyc = 1'b0;
        tick;
        for (int a = 11; a <= 20; a++) chk("mem_burst", mem[a], 200 + a);
        burst(1'b0, 11, 10, 0);
        for (int j = 0; j < 10; j++) chk("burst_rdat", rsp_dat[j], 211 + j);
        s_bus.cyc = 1'b0;
        tick;

        waits = 0;
        err_en = 1;
        burst(1'b0, 4, 3, 0);
        chk("err_kind0", rsp_kind[0], 1);
        chk("err_kind1", rsp_kind[1], 2);
        chk("err_kind2", rsp_kind[2], 1);
        chk("err_dat0", rsp_dat[0], 104);
        chk("err_dat2", rsp_dat[2], 106);
        s_bus.cyc = 1'b0;
        tick;
        both_en = 1;
        burst(1'b0, 4, 3, 0);
        chk("both_kind0", rsp_kind[0], 1);
        chk("both_kind1", rsp_kind[1], 2);
        chk("both_kind2", rsp_kind[2], 1);
        s_bus.cyc = 1'b0;
        err_en = 0;
        both_en = 0;
        tick;

        // Watchdog: slave never answers 0x7F.
        s_bus.cyc = 1'b1; s_bus.stb = 1'b1; s_bus.we = 1'b0; s_bus.adr = 16'h7F;
        tick;
        s_bus.stb = 1'b0;
        tick;
        chk("wd_stb_rise", m_bus.stb, 1);
        k = 0;
        while (k < 20) begin
            tick;
            k++;
            if (s_bus.err) break;
        end
        chk("wd_err_delay", k, 9);
        chk("wd_stb_drop", m_bus.stb, 0);
        chk("wd_no_ack", s_bus.ack, 0);
        tick;
        chk("wd_err_pulse", s_bus.err, 0);
        s_bus.cyc = 1'b0;
        tick;
        do_single(1'b0, 16'd3, 16'd103);

        // Abort with one request on the bus and three queued behind it.
        waits = 3;
        s_bus.cyc = 1'b1; s_bus.stb = 1'b1; s_bus.we = 1'b0;
        for (int j = 0; j < 4; j++) begin
            s_bus.adr = 16'(1 + j);
            tick;
        end
        chk("abort_full", s_bus.stall, 1);
        chk("abort_inflight", m_bus.stb, 1);
        s_bus.cyc = 1'b0;
        s_bus.stb = 1'b0;
        tick;
        chk("abort_m_cyc", m_bus.cyc, 0);
        chk("abort_m_stb", m_bus.stb, 0);
        chk("abort_stall", s_bus.stall, 0);
        s_bus.cyc = 1'b1;
        quiet = 1;
        for (int j = 0; j < 8; j++) begin
            tick;
            if (s_bus.ack || s_bus.err || m_bus.stb) quiet = 0;
        end
        chk("abort_quiet", quiet, 1);
        s_bus.cyc = 1'b0;
        waits = 0;
        tick;
        do_single(1'b0, 16'd7, 16'd107);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
